// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared widths and op/select codes for the ID/EX stage
package id_ex_stage_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W = 5;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_e;
  typedef enum logic [1:0] {RES_ALU, RES_LOAD, RES_PC4} res_src_e;
  typedef enum logic [1:0] {SRCA_RS1, SRCA_PC, SRCA_ZERO} src_a_sel_e;
  typedef enum logic [1:0] {FWD_REG, FWD_MEM, FWD_WB} fwd_sel_e;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: Decode inputs, M/W forwarding sources and EX outputs of the ID/EX stage
interface id_ex_stage_if import id_ex_stage_pkg::*; #(
  parameter int DATA_WIDTH = DATA_W,
  parameter int REG_ADDR_W = REG_W
);
  logic flush, valid_d, src_b_imm_d, regwrite_d, memwrite_d, branch_d, jump_d;
  logic [DATA_WIDTH-1:0] pc_d, rd1_d, rd2_d, imm_d;
  logic [REG_ADDR_W-1:0] rs1_d, rs2_d, rd_d;
  logic [3:0] alu_ctrl_d;
  logic [1:0] src_a_sel_d, result_src_d;
  logic [REG_ADDR_W-1:0] rd_m, rd_w;
  logic regwrite_m, regwrite_w;
  logic [DATA_WIDTH-1:0] alu_result_m, result_w;
  logic stall_fd, valid_e, regwrite_e, memwrite_e, branch_e, jump_e;
  logic [3:0] alu_ctrl_e;
  logic [DATA_WIDTH-1:0] src_a_e, src_b_e, write_data_e, pc_e, imm_e;
  logic [REG_ADDR_W-1:0] rd_e;
  logic [1:0] result_src_e;
  modport slave (
    input flush, valid_d, src_b_imm_d, regwrite_d, memwrite_d, branch_d, jump_d,
    input pc_d, rd1_d, rd2_d, imm_d, rs1_d, rs2_d, rd_d, alu_ctrl_d, src_a_sel_d, result_src_d,
    input rd_m, rd_w, regwrite_m, regwrite_w, alu_result_m, result_w,
    output stall_fd, valid_e, regwrite_e, memwrite_e, branch_e, jump_e,
    output alu_ctrl_e, src_a_e, src_b_e, write_data_e, pc_e, imm_e, rd_e, result_src_e
  );
  modport master (
    output flush, valid_d, src_b_imm_d, regwrite_d, memwrite_d, branch_d, jump_d,
    output pc_d, rd1_d, rd2_d, imm_d, rs1_d, rs2_d, rd_d, alu_ctrl_d, src_a_sel_d, result_src_d,
    output rd_m, rd_w, regwrite_m, regwrite_w, alu_result_m, result_w,
    input stall_fd, valid_e, regwrite_e, memwrite_e, branch_e, jump_e,
    input alu_ctrl_e, src_a_e, src_b_e, write_data_e, pc_e, imm_e, rd_e, result_src_e
  );
endinterface

// File: rtl/id_ex_stage_fwd_sel.sv
// id_ex_stage_fwd_sel: resolve one source register against the MEM and WB results
module id_ex_stage_fwd_sel import id_ex_stage_pkg::*; #(
  parameter int DATA_WIDTH = DATA_W,
  parameter int REG_ADDR_W = REG_W
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [DATA_WIDTH-1:0] reg_val,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  regwrite_m,
  input  logic [DATA_WIDTH-1:0] alu_result_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  regwrite_w,
  input  logic [DATA_WIDTH-1:0] result_w,
  output logic [DATA_WIDTH-1:0] fwd_val
);
  fwd_sel_e sel;
  // youngest in-flight writer of rs wins; x0 always reads the register value
  always_comb begin
    sel = rs == '0 ? FWD_REG :
          (regwrite_m && rd_m == rs) ? FWD_MEM :
          (regwrite_w && rd_w == rs) ? FWD_WB : FWD_REG;
    fwd_val = sel == FWD_MEM ? alu_result_m : sel == FWD_WB ? result_w : reg_val;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and load-use hazard detection
module id_ex_stage import id_ex_stage_pkg::*; #(
  parameter int DATA_WIDTH = DATA_W,
  parameter int REG_ADDR_W = REG_W
) (
  input logic clk,
  input logic rst_n,
  id_ex_stage_if.slave bus
);
  logic [DATA_WIDTH-1:0] rd1_e, rd2_e, fwd_a, fwd_b;
  logic [REG_ADDR_W-1:0] rs1_e, rs2_e;
  logic [1:0] src_a_sel_e;
  logic src_b_imm_e, load_use;
  assign load_use = bus.valid_e && bus.result_src_e == RES_LOAD && bus.rd_e != '0 && bus.valid_d &&
                    (bus.rd_e == bus.rs1_d || bus.rd_e == bus.rs2_d);
  assign bus.stall_fd = load_use && !bus.flush;
  // E register: clear on reset, bubble on flush or load-use, otherwise capture Decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.valid_e <= 1'b0;
      bus.regwrite_e <= 1'b0;
      bus.memwrite_e <= 1'b0;
      bus.branch_e <= 1'b0;
      bus.jump_e <= 1'b0;
      bus.alu_ctrl_e <= '0;
      bus.result_src_e <= '0;
      bus.rd_e <= '0;
      bus.pc_e <= '0;
      bus.imm_e <= '0;
      rd1_e <= '0;
      rd2_e <= '0;
      rs1_e <= '0;
      rs2_e <= '0;
      src_a_sel_e <= '0;
      src_b_imm_e <= 1'b0;
    end else if (bus.flush || load_use) begin
      bus.valid_e <= 1'b0;
      bus.regwrite_e <= 1'b0;
      bus.memwrite_e <= 1'b0;
      bus.branch_e <= 1'b0;
      bus.jump_e <= 1'b0;
    end else begin
      bus.valid_e <= bus.valid_d;
      bus.regwrite_e <= bus.valid_d && bus.regwrite_d;
      bus.memwrite_e <= bus.valid_d && bus.memwrite_d;
      bus.branch_e <= bus.valid_d && bus.branch_d;
      bus.jump_e <= bus.valid_d && bus.jump_d;
      bus.alu_ctrl_e <= bus.alu_ctrl_d;
      bus.result_src_e <= bus.result_src_d;
      bus.rd_e <= bus.rd_d;
      bus.pc_e <= bus.pc_d;
      bus.imm_e <= bus.imm_d;
      rd1_e <= bus.rd1_d;
      rd2_e <= bus.rd2_d;
      rs1_e <= bus.rs1_d;
      rs2_e <= bus.rs2_d;
      src_a_sel_e <= bus.src_a_sel_d;
      src_b_imm_e <= bus.src_b_imm_d;
    end
  end
  id_ex_stage_fwd_sel #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs(rs1_e), .reg_val(rd1_e),
    .rd_m(bus.rd_m), .regwrite_m(bus.regwrite_m), .alu_result_m(bus.alu_result_m),
    .rd_w(bus.rd_w), .regwrite_w(bus.regwrite_w), .result_w(bus.result_w),
    .fwd_val(fwd_a)
  );
  id_ex_stage_fwd_sel #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs(rs2_e), .reg_val(rd2_e),
    .rd_m(bus.rd_m), .regwrite_m(bus.regwrite_m), .alu_result_m(bus.alu_result_m),
    .rd_w(bus.rd_w), .regwrite_w(bus.regwrite_w), .result_w(bus.result_w),
    .fwd_val(fwd_b)
  );
  // ALU operands and store data from the forwarded sources; A-select 3 reads as zero
  always_comb begin
    bus.src_a_e = src_a_sel_e == SRCA_RS1 ? fwd_a : src_a_sel_e == SRCA_PC ? bus.pc_e : '0;
    bus.src_b_e = src_b_imm_e ? bus.imm_e : fwd_b;
    bus.write_data_e = fwd_b;
  end
endmodule
